// File: rtl/reset_seq_pkg.sv
// Package: reset_seq_pkg
// Shared definitions for the reset sequencer slice.
// - state_e: FSM state encodings.
// - idx_width(n_dom): width of the domain index, never below 1 bit.
// - hold_width(hold_cyc): width of the hold counter; it can reach hold_cyc.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    StAssert  = 2'd0,
    StRelease = 2'd1,
    StDone    = 2'd2
  } state_e;

  function automatic int unsigned idx_width(input int unsigned n_dom);
    return (n_dom > 1) ? $clog2(n_dom) : 1;
  endfunction

  // The counter is incremented once more on the cycle it leaves ASSERT,
  // so it has to be able to hold the value hold_cyc itself.
  function automatic int unsigned hold_width(input int unsigned hold_cyc);
    return $clog2(hold_cyc + 1);
  endfunction

endpackage

// File: rtl/reset_seq_ctrl_if.sv
// Interface: reset_seq_ctrl_if
// Control/status bundle of the reset sequencer.
//   test_shift  master->slave  force every domain out of reset
//   dly_cfg     master->slave  release spacing D (releases are D+1 cycles apart)
//   sw_rst_req  master->slave  software re-reset request (level)
//   sw_rst_ack  slave->master  one-cycle pulse when a software sequence completes
//   dom_rst_n   slave->master  per-domain active-low resets
//   seq_done    slave->master  all domains released
//   busy        slave->master  sequence in progress
// The sequencer connects to the slave modport, its driver to the master modport.
interface reset_seq_ctrl_if #(
  parameter int unsigned N_DOM = 4,
  parameter int unsigned CNT_W = 8
);

  logic             test_shift;
  logic [CNT_W-1:0] dly_cfg;
  logic             sw_rst_req;
  logic             sw_rst_ack;
  logic [N_DOM-1:0] dom_rst_n;
  logic             seq_done;
  logic             busy;

  modport master (
    output test_shift,
    output dly_cfg,
    output sw_rst_req,
    input  sw_rst_ack,
    input  dom_rst_n,
    input  seq_done,
    input  busy
  );

  modport slave (
    input  test_shift,
    input  dly_cfg,
    input  sw_rst_req,
    output sw_rst_ack,
    output dom_rst_n,
    output seq_done,
    output busy
  );

endinterface

// File: rtl/rst_dly_cnt.sv
// Module: rst_dly_cnt
// Loadable down-counter that sets the spacing between domain releases.
//   clk       clock
//   rst       synchronous active-high reset, clears the count
//   load      load load_val (has priority over dec)
//   load_val  value to load
//   dec       decrement; ignored once the count is zero (no wrap)
//   is_zero   count is zero
module rst_dly_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             is_zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign is_zero = (cnt_q == '0);

endmodule

// File: rtl/reset_seq_ctrl.sv
// Module: reset_seq_ctrl
// Releases N_DOM reset domains in order (domain 0 first) after holding all of
// them for HOLD_CYC cycles, with D+1 cycles between releases (D = dly_cfg,
// resampled at every counter reload). Software can restart the whole sequence
// from DONE; test_shift forces every domain out of reset without disturbing
// the sequencer.
//   clk   clock
//   rst   synchronous active-high reset, restarts the sequence
//   bus   reset_seq_ctrl_if slave modport (controls and status)
// All outputs are registered except the test_shift OR onto dom_rst_n.
module reset_seq_ctrl
  import reset_seq_pkg::*;
#(
  parameter int unsigned N_DOM    = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned HOLD_CYC = 8
) (
  input logic              clk,
  input logic              rst,
  reset_seq_ctrl_if.slave  bus
);

  localparam int unsigned IdxW  = idx_width(N_DOM);
  localparam int unsigned HoldW = hold_width(HOLD_CYC);

  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(N_DOM - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYC - 1);

  state_e             state_q;
  logic [HoldW-1:0]   hold_cnt_q;
  logic [IdxW-1:0]    idx_q;
  logic [N_DOM-1:0]   dom_q;
  logic               seq_done_q;
  logic               busy_q;
  logic               ack_q;
  logic               sw_flag_q;

  logic               cnt_load;
  logic               cnt_dec;
  logic               cnt_zero;

  // Spacing counter: loaded on the last hold cycle and after every release
  // except the final one, otherwise counted down while releasing.
  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      StAssert: begin
        cnt_load = (hold_cnt_q == HoldLast);
      end
      StRelease: begin
        cnt_dec  = !cnt_zero;
        cnt_load = cnt_zero && (idx_q != IdxLast);
      end
      default: ;
    endcase
  end

  rst_dly_cnt #(
    .CNT_W (CNT_W)
  ) u_dly_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (bus.dly_cfg),
    .dec      (cnt_dec),
    .is_zero  (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StAssert;
      hold_cnt_q <= '0;
      idx_q      <= '0;
      dom_q      <= '0;
      seq_done_q <= 1'b0;
      busy_q     <= 1'b1;
      ack_q      <= 1'b0;
      sw_flag_q  <= 1'b0;
    end else begin
      case (state_q)
        StAssert: begin
          hold_cnt_q <= hold_cnt_q + HoldW'(1);
          if (hold_cnt_q == HoldLast) begin
            state_q <= StRelease;
            idx_q   <= '0;
          end
        end
        StRelease: begin
          if (cnt_zero) begin
            dom_q <= dom_q | (N_DOM'(1) << idx_q);
            if (idx_q == IdxLast) begin
              state_q    <= StDone;
              seq_done_q <= 1'b1;
              busy_q     <= 1'b0;
              // Ack only sequences that software started.
              ack_q      <= sw_flag_q;
              sw_flag_q  <= 1'b0;
            end else begin
              idx_q <= idx_q + IdxW'(1);
            end
          end
        end
        StDone: begin
          ack_q <= 1'b0;
          if (bus.sw_rst_req) begin
            state_q    <= StAssert;
            dom_q      <= '0;
            seq_done_q <= 1'b0;
            busy_q     <= 1'b1;
            hold_cnt_q <= '0;
            sw_flag_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= StAssert;
        end
      endcase
    end
  end

  assign bus.dom_rst_n  = dom_q | {N_DOM{bus.test_shift}};
  assign bus.seq_done   = seq_done_q;
  assign bus.busy       = busy_q;
  assign bus.sw_rst_ack = ack_q;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Bench for reset_seq_ctrl: directed scenarios followed by random traffic,
// all checked cycle by cycle against a timeline model of release times.
module tb_reset_seq_ctrl;

  localparam int unsigned NDom    = 4;
  localparam int unsigned CntW    = 8;
  localparam int unsigned HoldCyc = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  reset_seq_ctrl_if #(.N_DOM(NDom), .CNT_W(CntW)) bus ();

  reset_seq_ctrl #(
    .N_DOM    (NDom),
    .CNT_W    (CntW),
    .HOLD_CYC (HoldCyc)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: how many domains are out, when the next one goes, and the
  // software-sequence bookkeeping.
  bit m_valid = 0;
  bit m_hold;
  bit m_done;
  bit m_ack;
  bit m_sw;
  int m_n;
  int m_start;
  int m_next;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Advance the model across the edge that ends cycle t.
  task automatic model_edge(input logic r, input int d, input logic req, input int t);
    if (r) begin
      m_valid = 1;
      m_n     = 0;
      m_done  = 0;
      m_ack   = 0;
      m_sw    = 0;
      m_hold  = 1;
      m_start = t + 1;
    end else if (!m_valid) begin
      // nothing known before the first reset
    end else if (m_done) begin
      m_ack = 0;
      if (req) begin
        m_n     = 0;
        m_done  = 0;
        m_sw    = 1;
        m_hold  = 1;
        m_start = t + 1;
      end
    end else if (m_hold) begin
      if (t == m_start + int'(HoldCyc) - 1) begin
        m_hold = 0;
        m_next = t + d + 2;
      end
    end else if (t + 1 == m_next) begin
      m_n++;
      if (m_n == int'(NDom)) begin
        m_done = 1;
        m_ack  = m_sw;
        m_sw   = 0;
      end else begin
        m_next = t + d + 2;
      end
    end
  endtask

  task automatic tick(input logic r, input logic ts, input logic [CntW-1:0] d, input logic req);
    logic [NDom-1:0] exp_dom;
    rst            = r;
    bus.test_shift = ts;
    bus.dly_cfg    = d;
    bus.sw_rst_req = req;
    @(posedge clk);
    model_edge(r, int'(d), req, cyc);
    cyc++;
    @(negedge clk);
    if (m_valid) begin
      exp_dom = m_done ? {NDom{1'b1}} : NDom'((1 << m_n) - 1);
      if (ts) exp_dom = {NDom{1'b1}};
      check_eq("dom_rst_n", 32'(bus.dom_rst_n), 32'(exp_dom));
      check_eq("seq_done", 32'(bus.seq_done), 32'(m_done));
      check_eq("busy", 32'(bus.busy), 32'(!m_done));
      check_eq("sw_rst_ack", 32'(bus.sw_rst_ack), 32'(m_ack));
    end
  endtask

  logic [CntW-1:0] cur_d;

  initial begin
    // Case 1: D=3 after reset.
    tick(1, 0, 3, 0);
    tick(1, 0, 3, 0);
    for (int c = 1; c <= 26; c++) begin
      tick(0, 0, 3, 0);
      if (c == 11) check_eq("c1_dom11", 32'(bus.dom_rst_n), 32'h0);
      if (c == 12) check_eq("c1_dom12", 32'(bus.dom_rst_n), 32'h1);
      if (c == 16) check_eq("c1_dom16", 32'(bus.dom_rst_n), 32'h3);
      if (c == 20) check_eq("c1_dom20", 32'(bus.dom_rst_n), 32'h7);
      if (c == 23) check_eq("c1_done23", 32'(bus.seq_done), 32'h0);
      if (c == 24) begin
        check_eq("c1_dom24", 32'(bus.dom_rst_n), 32'hf);
        check_eq("c1_done24", 32'(bus.seq_done), 32'h1);
        check_eq("c1_ack24", 32'(bus.sw_rst_ack), 32'h0);
      end
    end

    // Case 3: software re-reset from DONE, D=3.
    tick(0, 0, 3, 1);
    check_eq("c3_dom_s1", 32'(bus.dom_rst_n), 32'h0);
    check_eq("c3_busy_s1", 32'(bus.busy), 32'h1);
    for (int k = 2; k <= 27; k++) begin
      tick(0, 0, 3, 0);
      if (k == 24) check_eq("c3_dom_s24", 32'(bus.dom_rst_n), 32'h7);
      if (k == 25) begin
        check_eq("c3_dom_s25", 32'(bus.dom_rst_n), 32'hf);
        check_eq("c3_ack_s25", 32'(bus.sw_rst_ack), 32'h1);
      end
      if (k == 26) check_eq("c3_ack_s26", 32'(bus.sw_rst_ack), 32'h0);
    end

    // Case 2: D=0, one release per cycle.
    tick(1, 0, 0, 0);
    for (int c = 1; c <= 14; c++) begin
      tick(0, 0, 0, 0);
      if (c == 8)  check_eq("c2_dom8", 32'(bus.dom_rst_n), 32'h0);
      if (c == 9)  check_eq("c2_dom9", 32'(bus.dom_rst_n), 32'h1);
      if (c == 10) check_eq("c2_dom10", 32'(bus.dom_rst_n), 32'h3);
      if (c == 12) begin
        check_eq("c2_dom12", 32'(bus.dom_rst_n), 32'hf);
        check_eq("c2_done12", 32'(bus.seq_done), 32'h1);
      end
    end

    // Case 4: reset mid-sequence at cycle 17.
    tick(1, 0, 3, 0);
    for (int c = 1; c <= 16; c++) tick(0, 0, 3, 0);
    check_eq("c4_dom16", 32'(bus.dom_rst_n), 32'h3);
    tick(1, 0, 3, 0);
    check_eq("c4_dom18", 32'(bus.dom_rst_n), 32'h0);
    check_eq("c4_busy18", 32'(bus.busy), 32'h1);
    for (int k = 1; k <= 12; k++) begin
      tick(0, 0, 3, 0);
      if (k == 11) check_eq("c4_dom_r11", 32'(bus.dom_rst_n), 32'h0);
      if (k == 12) check_eq("c4_dom_r12", 32'(bus.dom_rst_n), 32'h1);
    end

    // Case 5: test_shift during ASSERT, dropped at cycle 14.
    tick(1, 1, 3, 0);
    for (int c = 1; c <= 25; c++) begin
      tick(0, (c < 14), 3, 0);
      if (c == 3)  check_eq("c5_dom3", 32'(bus.dom_rst_n), 32'hf);
      if (c == 3)  check_eq("c5_busy3", 32'(bus.busy), 32'h1);
      if (c == 14) check_eq("c5_dom14", 32'(bus.dom_rst_n), 32'h1);
      if (c == 24) check_eq("c5_done24", 32'(bus.seq_done), 32'h1);
    end

    // Case 6: request held during RELEASE is dropped; no new sequence.
    tick(1, 0, 2, 0);
    for (int c = 1; c <= 40; c++) begin
      tick(0, 0, 2, (c >= 10 && c <= 20));
      if (c == 20) check_eq("c6_done20", 32'(bus.seq_done), 32'h1);
      if (c == 40) begin
        check_eq("c6_done40", 32'(bus.seq_done), 32'h1);
        check_eq("c6_dom40", 32'(bus.dom_rst_n), 32'hf);
      end
    end

    // Random traffic, including mid-sequence spacing changes.
    cur_d = 3;
    tick(1, 0, cur_d, 0);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        cur_d = ($urandom_range(0, 9) == 0) ? CntW'($urandom_range(0, 40))
                                            : CntW'($urandom_range(0, 5));
      end
      tick(($urandom_range(0, 249) == 0), ($urandom_range(0, 15) == 0), cur_d,
           ($urandom_range(0, 5) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
